subtractor_serial: RTL and testbench

- Multi-cycle two's-complement subtractor computing diff = a - b one 4-bit slice per clock, LSB nibble first, with a rippled borrow.
- Operands enter on a valid/ready request port; results leave on a valid/ready response port with borrow, zero and signed-overflow flags.
- It is the inverse-direction companion to the ripple-carry adder chain. It serves datapath units that can trade latency for area.

---
 rtl/subtractor_serial.sv | 113 +++++++++++
 tb/tb_subtractor_serial.sv | 135 +++++++++++++
 2 files changed

// File: rtl/subtractor_serial.sv
// rtl/subtractor_serial.sv - nibble-serial two's-complement subtractor (diff = a - b)
// One 4-bit slice per clock, LSB first, with a rippled carry (borrow = ~carry).
module subtractor_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [3:0] a_nib, b_nib;
  logic [4:0] sum;

  // a - b is computed as a + ~b + 1; the initial carry of 1 supplies the +1.
  assign a_nib = a_q[{cnt_q, 2'b00} +: 4];
  assign b_nib = b_q[{cnt_q, 2'b00} +: 4];
  assign sum   = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        diff_d[{cnt_q, 2'b00} +: 4] = sum[3:0];
        carry_d = sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          borrow_d = ~sum[4];
          zero_d   = (diff_d == '0);
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// tb/tb_subtractor_serial.sv - directed self-checking bench for subtractor_serial
// All sampling is done on the falling edge; inputs change there too.
module tb_subtractor_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] diff;
  logic       borrow, zero, ovf;

  int checks = 0;
  int failures = 0;

  subtractor_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .a(a), .b(b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .diff(diff), .borrow(borrow), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_diff"},      diff, 0);
    check({tag, "_flags"},     {borrow, zero, ovf}, 0);
  endtask

  // Accept, then expect exactly two edges of BUSY before DONE; stray requests optional.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic ez,
                        input logic eo, input bit stray);
    @(negedge clk);
    check("pre_req_ready", req_ready, 1);
    a = av; b = bv; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("k_req_ready", req_ready, 0);
    check("k_rsp_valid", rsp_valid, 0);
    if (stray) begin
      req_valid = 1'b1; a = ~av; b = av;
    end
    @(negedge clk);
    req_valid = 1'b0; a = 8'hA5; b = 8'h3C;
    check("k1_req_ready", req_ready, 0);
    check("k1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("k2_rsp_valid", rsp_valid, 1);
    check("k2_req_ready", req_ready, 0);
    check("diff", diff, ed);
    check("borrow", borrow, eb);
    check("zero", zero, ez);
    check("ovf", ovf, eo);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ret_rsp_valid", rsp_valid, 0);
    check("ret_req_ready", req_ready, 1);
  endtask

  initial begin
    #2;
    check_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 8'h02, 0, 0, 0, 0);
    run_op(8'h03, 8'h05, 8'hFE, 1, 0, 0, 0);
    run_op(8'h80, 8'h01, 8'h7F, 0, 0, 1, 0);
    run_op(8'h7F, 8'hFF, 8'h80, 1, 0, 1, 0);
    run_op(8'h5A, 8'h5A, 8'h00, 0, 1, 0, 1);

    // Back-pressure: result must hold while inputs churn.
    @(negedge clk);
    a = 8'h10; b = 8'h01; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_diff", diff, 8'h0F);
      check("bp_flags", {borrow, zero, ovf}, 3'b000);
      a = 8'(i * 37); b = 8'(i + 200); req_valid = i[0];
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp_hold_diff", diff, 8'h0F);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ret_rsp_valid", rsp_valid, 0);
    check("bp_ret_req_ready", req_ready, 1);
    run_op(8'h20, 8'h30, 8'hF0, 1, 0, 0, 0);

    // Reset one cycle into BUSY aborts with no clock needed.
    @(negedge clk);
    a = 8'h33; b = 8'h11; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_busy");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    run_op(8'h09, 8'h04, 8'h05, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
